// File: rtl/uart_timer_pkg.sv
// Shared types and limits for the receive-path bit/packet timer.
package uart_timer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OFFSET = 2'd1,
        RUN    = 2'd2
    } timer_state_t;

    localparam int unsigned MIN_CLKS_PER_BIT = 2;
    localparam int unsigned MIN_BITS         = 1;

endpackage

// File: rtl/sync_flex_counter.sv
// Counter with synchronous reset/clear that counts 1..rollover_val and wraps back to 1.
module sync_flex_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             count_enable,
    input  logic [WIDTH-1:0] rollover_val,
    output logic [WIDTH-1:0] count_out,
    output logic             rollover_flag
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_enable) begin
            count_d = (count_q == rollover_val) ? WIDTH'(1) : count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_out     = count_q;
    assign rollover_flag = (count_q == rollover_val);

endmodule

// File: rtl/uart_bit_timer.sv
// Runtime-configurable bit/packet timer: emits shift_strobe every N clocks (optionally offset
// by N/2) for B bits, with start/abort handshake and busy/bit_index status.
module uart_bit_timer
    import uart_timer_pkg::*;
#(
    parameter int unsigned CNT_BITS     = 4,
    parameter int unsigned BIT_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    sample_mid,
    input  logic [CNT_BITS-1:0]     clks_per_bit,
    input  logic [BIT_CNT_BITS-1:0] bits_per_packet,
    output logic                    shift_strobe,
    output logic                    packet_done,
    output logic                    busy,
    output logic [BIT_CNT_BITS-1:0] bit_index
);

    timer_state_t            state_q, state_d;
    logic [CNT_BITS-1:0]     n_q, n_d;
    logic [BIT_CNT_BITS-1:0] b_q, b_d;

    logic [CNT_BITS-1:0]     n_in, half_in, half_q, clk_rollover_val, clk_count;
    logic [BIT_CNT_BITS-1:0] b_in;
    logic                    clk_clear, clk_en, clk_roll;
    logic                    bit_clear, bit_en, bit_roll;
    logic                    strobe_raw, last_bit;

    assign n_in    = (clks_per_bit < CNT_BITS'(MIN_CLKS_PER_BIT)) ?
                     CNT_BITS'(MIN_CLKS_PER_BIT) : clks_per_bit;
    assign b_in    = (bits_per_packet < BIT_CNT_BITS'(MIN_BITS)) ?
                     BIT_CNT_BITS'(MIN_BITS) : bits_per_packet;
    assign half_in = n_in >> 1;
    assign half_q  = n_q >> 1;

    // The clock counter doubles as the offset timer while in OFFSET.
    assign clk_rollover_val = (state_q == OFFSET) ? half_q : n_q;

    assign last_bit     = (bit_index == b_q - BIT_CNT_BITS'(1));
    assign strobe_raw   = (state_q == RUN) && clk_roll;
    assign shift_strobe = strobe_raw && !abort;
    assign packet_done  = shift_strobe && last_bit;
    assign busy         = (state_q != IDLE);
    assign bit_en       = shift_strobe && !bit_roll;

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        b_d       = b_q;
        clk_clear = 1'b0;
        clk_en    = 1'b0;
        bit_clear = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    n_d       = n_in;
                    b_d       = b_in;
                    bit_clear = 1'b1;
                    clk_en    = 1'b1;
                    state_d   = (sample_mid && (half_in != '0)) ? OFFSET : RUN;
                end
            end
            OFFSET: begin
                if (abort) begin
                    state_d   = IDLE;
                    clk_clear = 1'b1;
                    bit_clear = 1'b1;
                end else begin
                    clk_en = 1'b1;
                    if (clk_roll) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_d   = IDLE;
                    clk_clear = 1'b1;
                    bit_clear = 1'b1;
                end else if (clk_roll && last_bit) begin
                    state_d   = IDLE;
                    clk_clear = 1'b1;
                end else begin
                    clk_en = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            n_q     <= CNT_BITS'(MIN_CLKS_PER_BIT);
            b_q     <= BIT_CNT_BITS'(MIN_BITS);
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            b_q     <= b_d;
        end
    end

    sync_flex_counter #(
        .WIDTH (CNT_BITS)
    ) u_clk_cnt (
        .clk           (clk),
        .rst           (rst),
        .clear         (clk_clear),
        .count_enable  (clk_en),
        .rollover_val  (clk_rollover_val),
        .count_out     (clk_count),
        .rollover_flag (clk_roll)
    );

    sync_flex_counter #(
        .WIDTH (BIT_CNT_BITS)
    ) u_bit_cnt (
        .clk           (clk),
        .rst           (rst),
        .clear         (bit_clear),
        .count_enable  (bit_en),
        .rollover_val  (b_q),
        .count_out     (bit_index),
        .rollover_flag (bit_roll)
    );

    // Raw count is only observed through its rollover flag.
    logic unused_clk_count;
    assign unused_clk_count = ^clk_count;

endmodule
